timer_prescaler: RTL

TIMER_PRESCALER -- requirements
Module: timer_prescaler

---
 rtl/timer_prescaler.sv | 119 +++++++++++
 1 files changed

// File: rtl/timer_prescaler.sv
// -----------------------------------------------------------------------------
// timer_prescaler
//
// One free-running prescaler counter is shared by N_CH timer channels. Each
// channel has a 3-bit clock-select code, and the module produces one registered
// count-enable pulse per channel.
//
// Select codes (per channel, S[3i+2:3i]):
//   000 stopped         001 every cycle     010 /8       011 /64
//   100 /256            101 /1024           110 Tpin fall  111 Tpin rise
//
// Build option:
//   TIMER_PRESCALER_EXT_CLK_EN  When defined, the Tpin synchronizers and the
//                               edge modes 110/111 are built. When it is not
//                               defined, Tpin is ignored and 110/111 behave
//                               like 000.
//
// Parameters:
//   N_CH  number of channels sharing the prescaler (1..4)
//   PS_W  prescaler width in bits (>= 10)
//
// Ports:
//   sysClock  in   system clock, all state on its rising edge
//   rst       in   synchronous active-high reset (priority over everything)
//   S         in   3*N_CH clock-select codes
//   psr       in   synchronous prescaler reset request (clears pcnt)
//   Tpin      in   N_CH external clock pins, asynchronous to sysClock
//   tick      out  N_CH one-cycle count-enable pulses, registered
//   pcnt      out  current prescaler count, for debug
// -----------------------------------------------------------------------------
module timer_prescaler #(
  parameter int unsigned N_CH = 2,
  parameter int unsigned PS_W = 10
) (
  input  logic              sysClock,
  input  logic              rst,
  input  logic [3*N_CH-1:0] S,
  input  logic              psr,
  input  logic [N_CH-1:0]   Tpin,
  output logic [N_CH-1:0]   tick,
  output logic [PS_W-1:0]   pcnt
);

  // Prescaled tap hits. A psr in the same cycle suppresses the tick the tap
  // would otherwise raise, because the counter phase restarts from 0.
  logic div8_hit;
  logic div64_hit;
  logic div256_hit;
  logic div1024_hit;

  assign div8_hit    = (&pcnt[2:0]) & ~psr;
  assign div64_hit   = (&pcnt[5:0]) & ~psr;
  assign div256_hit  = (&pcnt[7:0]) & ~psr;
  assign div1024_hit = (&pcnt[9:0]) & ~psr;

`ifdef TIMER_PRESCALER_EXT_CLK_EN
  // sync0/sync1 form the synchronizer; hist holds the previous synchronized
  // level. They run in every mode so that switching into an edge mode sees
  // valid history and does not produce a spurious tick.
  logic [N_CH-1:0] sync0;
  logic [N_CH-1:0] sync1;
  logic [N_CH-1:0] hist;
  logic [N_CH-1:0] pin_rise;
  logic [N_CH-1:0] pin_fall;

  always_ff @(posedge sysClock) begin
    if (rst) begin
      sync0 <= '0;
      sync1 <= '0;
      hist  <= '0;
    end else begin
      sync0 <= Tpin;
      sync1 <= sync0;
      hist  <= sync1;
    end
  end

  assign pin_rise = sync1 & ~hist;
  assign pin_fall = ~sync1 & hist;
`else
  logic unused_tpin;
  assign unused_tpin = ^Tpin;
`endif

  logic [N_CH-1:0] tick_next;

  always_comb begin
    tick_next = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      case (S[3*i +: 3])
        3'b001:  tick_next[i] = 1'b1;
        3'b010:  tick_next[i] = div8_hit;
        3'b011:  tick_next[i] = div64_hit;
        3'b100:  tick_next[i] = div256_hit;
        3'b101:  tick_next[i] = div1024_hit;
`ifdef TIMER_PRESCALER_EXT_CLK_EN
        3'b110:  tick_next[i] = pin_fall[i];
        3'b111:  tick_next[i] = pin_rise[i];
`endif
        default: tick_next[i] = 1'b0;
      endcase
    end
  end

  always_ff @(posedge sysClock) begin
    if (rst) begin
      pcnt <= '0;
      tick <= '0;
    end else begin
      if (psr) begin
        pcnt <= '0;
      end else begin
        pcnt <= pcnt + PS_W'(1);
      end
      tick <= tick_next;
    end
  end

endmodule
